// File: rtl/dds_word_bank.sv
// -----------------------------------------------------------------------------
// dds_word_bank
// Frequency/phase tuning-word register bank for a multi-channel DDS.
// Decodes one-cycle keypad command strobes into per-channel frequency and phase
// word updates. Every effective word change produces a stretched, retriggerable
// DDS reset pulse on that channel. The pulse starts one cycle after the new word
// appears, so the DDS core samples a settled word.
//
// Build option:
//   DDS_WORD_DEC_EN  When defined, ops 3..5 (-1/-10/-100) subtract. When it is
//                    undefined, those ops are rejected with key_err and no
//                    subtract datapath is built.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   reset      synchronous, active-high reset
//   key_pulse  one-cycle command strobe
//   key_ch     target channel (CHW bits)
//   key_sel    0 = frequency word, 1 = phase word
//   key_op     0:+1 1:+10 2:+100 3:-1 4:-10 5:-100 6:load min 7:load max
//   fword      frequency words; channel k at [k*FW +: FW]
//   pword      phase words;     channel k at [k*PW +: PW]
//   ch_rst     per-channel DDS reset
//   dds_rst    OR of ch_rst
//   key_err    one-cycle pulse when a command is rejected
//
// Handshake: key_pulse is a plain strobe with no ready/back-pressure. A command
// is accepted on the edge where key_pulse=1 and key_ch<CH. The bank is always
// ready, including while a reset pulse is active.
// -----------------------------------------------------------------------------
module dds_word_bank #(
  parameter int CH      = 2,
  parameter int FW      = 16,
  parameter int PW      = 12,
  parameter int RST_LEN = 4,
  parameter int SAT     = 1,
  localparam int CHW    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_pulse,
  input  logic [CHW-1:0]   key_ch,
  input  logic             key_sel,
  input  logic [2:0]       key_op,
  output logic [CH*FW-1:0] fword,
  output logic [CH*PW-1:0] pword,
  output logic [CH-1:0]    ch_rst,
  output logic             dds_rst,
  output logic             key_err
);

  localparam logic [FW-1:0] F_ONE = FW'(1);
  localparam logic [FW-1:0] F_MAX = '1;
  localparam logic [PW-1:0] P_MAX = '1;
  localparam logic [7:0]    LEN   = 8'(RST_LEN);

  logic [FW-1:0] r_fword [CH];
  logic [PW-1:0] r_pword [CH];
  logic [7:0]    r_cnt   [CH];
  // Effective change seen on the previous edge; it loads the counter one cycle
  // later, so ch_rst rises after the word has settled.
  logic [CH-1:0] r_pend;
  logic          r_err;

  logic [CH-1:0] w_hit;
  logic [FW-1:0] w_old_f;
  logic [PW-1:0] w_old_p;
  logic          w_ch_ok;
  logic          w_op_ok;
  logic          w_acc;
  logic [6:0]    w_step;
  logic [FW:0]   w_f_add;
  logic [PW:0]   w_p_add;
  logic [FW-1:0] w_f_res;
  logic [FW-1:0] w_new_f;
  logic [PW-1:0] w_new_p;
  logic          w_f_chg;
  logic          w_p_chg;
`ifdef DDS_WORD_DEC_EN
  logic [FW:0]   w_f_sub;
  logic [PW:0]   w_p_sub;
`endif

  always_comb begin
    w_hit   = '0;
    w_old_f = '0;
    w_old_p = '0;
    // Explicit mux rather than an array index so that an out-of-range key_ch
    // (CH not a power of two) never reads past the array.
    for (int k = 0; k < CH; k++) begin
      if (int'(key_ch) == k) begin
        w_hit[k] = 1'b1;
        w_old_f  = r_fword[k];
        w_old_p  = r_pword[k];
      end
    end
    w_ch_ok = (int'(key_ch) < CH);

    case (key_op)
      3'd0, 3'd3: w_step = 7'd1;
      3'd1, 3'd4: w_step = 7'd10;
      default:    w_step = 7'd100;
    endcase

`ifdef DDS_WORD_DEC_EN
    w_op_ok = 1'b1;
`else
    w_op_ok = !((key_op >= 3'd3) && (key_op <= 3'd5));
`endif
    w_acc = key_pulse && w_ch_ok && w_op_ok;

    w_f_add = {1'b0, w_old_f} + {{(FW-6){1'b0}}, w_step};
    w_p_add = {1'b0, w_old_p} + {{(PW-6){1'b0}}, w_step};
`ifdef DDS_WORD_DEC_EN
    w_f_sub = {1'b0, w_old_f} - {{(FW-6){1'b0}}, w_step};
    w_p_sub = {1'b0, w_old_p} - {{(PW-6){1'b0}}, w_step};
`endif

    case (key_op)
      3'd6: begin
        w_f_res = F_ONE;
        w_new_p = '0;
      end
      3'd7: begin
        w_f_res = F_MAX;
        w_new_p = P_MAX;
      end
`ifdef DDS_WORD_DEC_EN
      3'd3, 3'd4, 3'd5: begin
        // Borrow out of the extra bit means the result went below zero.
        if ((SAT != 0) && w_f_sub[FW]) w_f_res = F_ONE;
        else                           w_f_res = w_f_sub[FW-1:0];
        w_new_p = w_p_sub[PW-1:0];
      end
`endif
      default: begin
        if ((SAT != 0) && w_f_add[FW]) w_f_res = F_MAX;
        else                           w_f_res = w_f_add[FW-1:0];
        w_new_p = w_p_add[PW-1:0];
      end
    endcase

    // A frequency word of 0 would stall the DDS, so 0 always becomes 1.
    w_new_f = (w_f_res == '0) ? F_ONE : w_f_res;
    w_f_chg = (w_new_f != w_old_f);
    w_p_chg = (w_new_p != w_old_p);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < CH; k++) begin
        r_fword[k] <= F_ONE;
        r_pword[k] <= '0;
        r_cnt[k]   <= '0;
      end
      r_pend <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= key_pulse && !w_acc;
      for (int k = 0; k < CH; k++) begin
        r_pend[k] <= 1'b0;
        if (w_acc && w_hit[k]) begin
          if (!key_sel) begin
            r_fword[k] <= w_new_f;
            r_pend[k]  <= w_f_chg;
          end else begin
            r_pword[k] <= w_new_p;
            r_pend[k]  <= w_p_chg;
          end
        end
        // Reload on every pending change gives the retrigger behaviour.
        if (r_pend[k])           r_cnt[k] <= LEN;
        else if (r_cnt[k] != '0) r_cnt[k] <= r_cnt[k] - 8'd1;
      end
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_out
    assign fword[k*FW +: FW] = r_fword[k];
    assign pword[k*PW +: PW] = r_pword[k];
    assign ch_rst[k]         = (r_cnt[k] != '0);
  end

  assign dds_rst = |ch_rst;
  assign key_err = r_err;

endmodule

// File: tb/tb_dds_word_bank.sv
// -----------------------------------------------------------------------------
// tb_dds_word_bank
// Directed bench for dds_word_bank. Instance a is a saturating two-channel bank
// (CH=2, SAT=1). Instance b is a wrapping three-channel bank (CH=3, SAT=0), so
// that an out-of-range key_ch (3) can be encoded. Expected values are hand
// computed. Outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_dds_word_bank;

  logic        clk;
  logic        reset;

  logic        key_pulse_a;
  logic [0:0]  key_ch_a;
  logic        key_sel_a;
  logic [2:0]  key_op_a;
  logic [31:0] fword_a;
  logic [23:0] pword_a;
  logic [1:0]  ch_rst_a;
  logic        dds_rst_a;
  logic        key_err_a;

  logic        key_pulse_b;
  logic [1:0]  key_ch_b;
  logic        key_sel_b;
  logic [2:0]  key_op_b;
  logic [47:0] fword_b;
  logic [35:0] pword_b;
  logic [2:0]  ch_rst_b;
  logic        dds_rst_b;
  logic        key_err_b;

  int checks = 0;
  int errors = 0;

  dds_word_bank #(.CH(2), .FW(16), .PW(12), .RST_LEN(4), .SAT(1)) u_a (
    .clk(clk), .reset(reset), .key_pulse(key_pulse_a), .key_ch(key_ch_a),
    .key_sel(key_sel_a), .key_op(key_op_a), .fword(fword_a), .pword(pword_a),
    .ch_rst(ch_rst_a), .dds_rst(dds_rst_a), .key_err(key_err_a)
  );

  dds_word_bank #(.CH(3), .FW(16), .PW(12), .RST_LEN(4), .SAT(0)) u_b (
    .clk(clk), .reset(reset), .key_pulse(key_pulse_b), .key_ch(key_ch_b),
    .key_sel(key_sel_b), .key_op(key_op_b), .fword(fword_b), .pword(pword_b),
    .ch_rst(ch_rst_b), .dds_rst(dds_rst_b), .key_err(key_err_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd_a(input int ch, input int sel, input int op);
    key_ch_a    = 1'(ch);
    key_sel_a   = 1'(sel);
    key_op_a    = 3'(op);
    key_pulse_a = 1'b1;
    tick();
    key_pulse_a = 1'b0;
  endtask

  task automatic cmd_b(input int ch, input int sel, input int op);
    key_ch_b    = 2'(ch);
    key_sel_b   = 1'(sel);
    key_op_b    = 3'(op);
    key_pulse_b = 1'b1;
    tick();
    key_pulse_b = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    key_pulse_a = 1'b0; key_ch_a = '0; key_sel_a = 1'b0; key_op_a = '0;
    key_pulse_b = 1'b0; key_ch_b = '0; key_sel_b = 1'b0; key_op_b = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // reset state
    chk("rst_fword_a", 64'(fword_a), 64'h0001_0001);
    chk("rst_pword_a", 64'(pword_a), 64'h0);
    chk("rst_dds_rst_a", 64'(dds_rst_a), 64'h0);
    chk("rst_key_err_a", 64'(key_err_a), 64'h0);
    chk("rst_fword_b", 64'(fword_b), 64'h0001_0001_0001);

    // ch0 freq +100 three times, back to back
    cmd_a(0, 0, 2);
    chk("add100_1", 64'(fword_a[15:0]), 64'd101);
    chk("add100_1_rst_late", 64'(ch_rst_a), 64'h0);
    cmd_a(0, 0, 2);
    chk("add100_2", 64'(fword_a[15:0]), 64'd201);
    chk("add100_2_rst", 64'(ch_rst_a), 64'h1);
    cmd_a(0, 0, 2);
    chk("add100_3", 64'(fword_a[15:0]), 64'd301);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pulse_high", 64'({ch_rst_a, dds_rst_a}), 64'h3);
    end
    tick();
    chk("pulse_end", 64'({ch_rst_a, dds_rst_a}), 64'h0);

    // saturation on ch1
    cmd_a(1, 0, 7);
    chk("load_max", 64'(fword_a[31:16]), 64'd65535);
    repeat (6) tick();
    chk("quiet", 64'(ch_rst_a), 64'h0);
    cmd_a(1, 0, 0);
    chk("sat_inc", 64'(fword_a[31:16]), 64'd65535);
    chk("sat_inc_err", 64'(key_err_a), 64'h0);
    tick();
    chk("sat_no_pulse_1", 64'(ch_rst_a), 64'h0);
    tick();
    chk("sat_no_pulse_2", 64'(dds_rst_a), 64'h0);
    cmd_a(1, 0, 3);
`ifdef DDS_WORD_DEC_EN
    chk("dec1", 64'(fword_a[31:16]), 64'd65534);
    chk("dec1_err", 64'(key_err_a), 64'h0);
    tick();
    chk("dec1_pulse", 64'(ch_rst_a), 64'h2);
`else
    chk("dec_rejected_word", 64'(fword_a[31:16]), 64'd65535);
    chk("dec_rejected_err", 64'(key_err_a), 64'h1);
    tick();
    chk("dec_rejected_no_pulse", 64'(ch_rst_a), 64'h0);
    chk("dec_err_one_cycle", 64'(key_err_a), 64'h0);
`endif
    repeat (6) tick();

    // phase on ch0
    cmd_a(0, 1, 1);
    chk("phase_add10", 64'(pword_a[11:0]), 64'd10);
    cmd_a(0, 1, 6);
    chk("phase_load_min", 64'(pword_a[11:0]), 64'd0);
    repeat (6) tick();

    // wrapping instance
    cmd_b(0, 0, 7);
    chk("b_load_max", 64'(fword_b[15:0]), 64'd65535);
    cmd_b(0, 0, 0);
    chk("b_wrap_to_one", 64'(fword_b[15:0]), 64'd1);
    tick();
    chk("b_wrap_pulse", 64'(ch_rst_b[0]), 64'h1);
    cmd_b(2, 1, 7);
    chk("b_phase_max", 64'(pword_b[35:24]), 64'd4095);
    cmd_b(2, 1, 1);
    chk("b_phase_wrap", 64'(pword_b[35:24]), 64'd9);
    tick();
    chk("b_phase_pulse", 64'(ch_rst_b[2]), 64'h1);
    cmd_b(1, 0, 6);
    chk("b_min_at_min", 64'(fword_b[31:16]), 64'd1);
    tick();
    chk("b_min_no_pulse", 64'(ch_rst_b[1]), 64'h0);
    cmd_b(3, 0, 0);
    chk("b_badch_err", 64'(key_err_b), 64'h1);
    chk("b_badch_fword", 64'(fword_b), 64'h0001_0001_0001);
    chk("b_badch_pword", 64'(pword_b), 64'h009_000_000);
    tick();
    chk("b_badch_err_clear", 64'(key_err_b), 64'h0);

    // retrigger on ch0 of instance a (ch0 freq is 301)
    cmd_a(0, 0, 0);
    chk("retrig_w1", 64'(fword_a[15:0]), 64'd302);
    tick();
    chk("retrig_rise", 64'(ch_rst_a[0]), 64'h1);
    cmd_a(0, 0, 0);
    chk("retrig_w2", 64'(fword_a[15:0]), 64'd303);
    chk("retrig_hold", 64'(ch_rst_a[0]), 64'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("retrig_ext", 64'(ch_rst_a[0]), 64'h1);
    end
    tick();
    chk("retrig_end", 64'(ch_rst_a[0]), 64'h0);

    // reset in the middle of a pulse, with a colliding command
    cmd_a(0, 0, 1);
    chk("pre_rst_word", 64'(fword_a[15:0]), 64'd313);
    tick();
    chk("pre_rst_pulse", 64'(ch_rst_a[0]), 64'h1);
    reset       = 1'b1;
    key_ch_a    = 1'b1;
    key_sel_a   = 1'b0;
    key_op_a    = 3'd7;
    key_pulse_a = 1'b1;
    tick();
    reset       = 1'b0;
    key_pulse_a = 1'b0;
    chk("mid_rst_fword", 64'(fword_a), 64'h0001_0001);
    chk("mid_rst_ch_rst", 64'({ch_rst_a, dds_rst_a}), 64'h0);
    tick();
    chk("post_rst_fword", 64'(fword_a), 64'h0001_0001);
    chk("post_rst_pword", 64'(pword_a), 64'h0);
    chk("post_rst_quiet", 64'({ch_rst_a, dds_rst_a, key_err_a}), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
